// File: rtl/opto_reader.sv
// opto_reader
//   Reads OPTO_NUM 32-bit period words from a byte-wide opto RAM after each
//   i_opto_make pulse. Each word is reassembled big-endian (byte 0 is the MSB)
//   and handed downstream over a valid/ready handshake. o_frame_done pulses
//   after the last word transfers.
//
// Parameters
//   OPTO_NUM  words per frame, 1..256
//   RD_LAT    RAM read latency in cycles from the o_opto_rden cycle, 1..3
//
// Ports
//   i_clk_50m       system clock, rising edge
//   i_rst_n         asynchronous active-low reset
//   i_opto_make     pulse: a complete frame is in the opto RAM
//   o_opto_rden     RAM read enable, one cycle per byte
//   o_opto_rdaddr   RAM byte address (4*word + byte)
//   i_opto_rddata   RAM read data
//   o_period_valid  period word available
//   o_period_data   reassembled period word
//   o_period_index  index of o_period_data within the frame
//   i_period_ready  downstream accepts the word
//   o_frame_done    pulse after the last word of a frame transfers
//   o_busy          frame in progress (cycle after accept through done cycle)
//   o_make_drop     pulse: i_opto_make arrived while busy and was ignored
//   o_period_sum    sum of the last frame's words (0 unless summing is built)
//
// Build option
//   OPTO_READER_SUM_EN  when defined, accumulates all transferred words of a
//                       frame (modulo 2^32) and presents the total on
//                       o_period_sum from the o_frame_done cycle onwards.
module opto_reader #(
  parameter int unsigned OPTO_NUM = 40,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic        i_clk_50m,
  input  logic        i_rst_n,
  input  logic        i_opto_make,
  output logic        o_opto_rden,
  output logic [9:0]  o_opto_rdaddr,
  input  logic [7:0]  i_opto_rddata,
  output logic        o_period_valid,
  output logic [31:0] o_period_data,
  output logic [7:0]  o_period_index,
  input  logic        i_period_ready,
  output logic        o_frame_done,
  output logic        o_busy,
  output logic        o_make_drop,
  output logic [31:0] o_period_sum
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] OUTPUT  = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam logic [7:0] LAST_WORD = 8'(OPTO_NUM - 1);
  localparam logic [1:0] LAT_LAST  = 2'(RD_LAT - 1);

  logic [2:0]  state_q, state_d;
  logic [1:0]  byte_q, byte_d;
  logic [1:0]  lat_q, lat_d;
  logic [7:0]  word_q, word_d;
  // Holds bytes 0..2 of the word being read; byte 3 joins them straight
  // into the output register.
  logic [23:0] shift_q, shift_d;
  logic        rden_q, rden_d;
  logic [9:0]  rdaddr_q, rdaddr_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  index_q, index_d;
  logic        done_q, done_d;
  logic        drop_q, drop_d;

  logic accept;
  logic xfer;
  logic last_xfer;

  assign accept    = (state_q == IDLE) && i_opto_make;
  // valid_q is high exactly while in OUTPUT, so this is valid & ready.
  assign xfer      = (state_q == OUTPUT) && i_period_ready;
  assign last_xfer = xfer && (word_q == LAST_WORD);

  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    lat_d    = lat_q;
    word_d   = word_q;
    shift_d  = shift_q;
    rden_d   = 1'b0;
    rdaddr_d = rdaddr_q;
    valid_d  = valid_q;
    data_d   = data_q;
    index_d  = index_q;
    done_d   = 1'b0;
    // Any make outside IDLE (including the DONE cycle) is dropped.
    drop_d   = i_opto_make && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = RD_REQ;
          rden_d   = 1'b1;
          rdaddr_d = '0;
          byte_d   = '0;
          word_d   = '0;
          lat_d    = '0;
        end
      end
      RD_REQ: begin
        state_d = RD_WAIT;
        lat_d   = '0;
      end
      RD_WAIT: begin
        if (lat_q == LAT_LAST) begin
          if (byte_q != 2'd3) begin
            shift_d  = {shift_q[15:0], i_opto_rddata};
            byte_d   = byte_q + 2'd1;
            state_d  = RD_REQ;
            rden_d   = 1'b1;
            rdaddr_d = {word_q, byte_q + 2'd1};
          end else begin
            state_d = OUTPUT;
            valid_d = 1'b1;
            data_d  = {shift_q, i_opto_rddata};
            index_d = word_q;
            byte_d  = '0;
          end
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      OUTPUT: begin
        // No read-ahead: the next word is fetched only after this one moves.
        if (xfer) begin
          valid_d = 1'b0;
          if (!last_xfer) begin
            word_d   = word_q + 8'd1;
            state_d  = RD_REQ;
            rden_d   = 1'b1;
            rdaddr_d = {word_q + 8'd1, 2'b00};
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        byte_d  = '0;
        word_d  = '0;
        lat_d   = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      byte_q   <= '0;
      lat_q    <= '0;
      word_q   <= '0;
      shift_q  <= '0;
      rden_q   <= 1'b0;
      rdaddr_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      index_q  <= '0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      byte_q   <= byte_d;
      lat_q    <= lat_d;
      word_q   <= word_d;
      shift_q  <= shift_d;
      rden_q   <= rden_d;
      rdaddr_q <= rdaddr_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      index_q  <= index_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
    end
  end

  assign o_opto_rden    = rden_q;
  assign o_opto_rdaddr  = rdaddr_q;
  assign o_period_valid = valid_q;
  assign o_period_data  = data_q;
  assign o_period_index = index_q;
  assign o_frame_done   = done_q;
  assign o_make_drop    = drop_q;
  assign o_busy         = (state_q != IDLE);

`ifdef OPTO_READER_SUM_EN
  logic [31:0] acc_q;
  logic [31:0] sum_q;

  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q <= '0;
      sum_q <= '0;
    end else if (accept) begin
      acc_q <= '0;
    end else if (xfer) begin
      acc_q <= acc_q + data_q;
      // Lands in the same cycle as o_frame_done.
      if (last_xfer) begin
        sum_q <= acc_q + data_q;
      end
    end
  end

  assign o_period_sum = sum_q;
`else
  assign o_period_sum = '0;
`endif

endmodule

// File: tb/tb_opto_reader.sv
module tb_opto_reader;
  localparam int NA = 40;
  localparam int NC = 8;
`ifdef OPTO_READER_SUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_n;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- DUT A: OPTO_NUM=40, RD_LAT=1 ----------------
  logic        make_a, rden_a, valid_a, ready_a, done_a, busy_a, drop_a;
  logic [9:0]  addr_a;
  logic [7:0]  rd_a, index_a;
  logic [31:0] data_a, sum_a;
  logic [31:0] mem_a [NA];

  opto_reader #(.OPTO_NUM(NA), .RD_LAT(1)) dut_a (
    .i_clk_50m(clk), .i_rst_n(rst_n), .i_opto_make(make_a), .o_opto_rden(rden_a),
    .o_opto_rdaddr(addr_a), .i_opto_rddata(rd_a), .o_period_valid(valid_a),
    .o_period_data(data_a), .o_period_index(index_a), .i_period_ready(ready_a),
    .o_frame_done(done_a), .o_busy(busy_a), .o_make_drop(drop_a), .o_period_sum(sum_a)
  );

  always @(posedge clk)
    if (rden_a) rd_a <= mem_a[int'(addr_a[9:2])][8*(3-int'(addr_a[1:0])) +: 8];

  // ---------------- DUT B: OPTO_NUM=1, RD_LAT=3 ----------------
  logic        make_b, rden_b, valid_b, ready_b, done_b, busy_b, drop_b;
  logic [9:0]  addr_b;
  logic [7:0]  rd_b, index_b, pipe_b1, pipe_b2;
  logic [31:0] data_b, sum_b;
  logic [31:0] mem_b0;

  opto_reader #(.OPTO_NUM(1), .RD_LAT(3)) dut_b (
    .i_clk_50m(clk), .i_rst_n(rst_n), .i_opto_make(make_b), .o_opto_rden(rden_b),
    .o_opto_rdaddr(addr_b), .i_opto_rddata(rd_b), .o_period_valid(valid_b),
    .o_period_data(data_b), .o_period_index(index_b), .i_period_ready(ready_b),
    .o_frame_done(done_b), .o_busy(busy_b), .o_make_drop(drop_b), .o_period_sum(sum_b)
  );

  always @(posedge clk) begin
    pipe_b1 <= rden_b ? mem_b0[8*(3-int'(addr_b[1:0])) +: 8] : 8'h00;
    pipe_b2 <= pipe_b1;
    rd_b    <= pipe_b2;
  end

  // ---------------- DUT C: OPTO_NUM=8, RD_LAT=1 ----------------
  logic        make_c, rden_c, valid_c, ready_c, done_c, busy_c, drop_c;
  logic [9:0]  addr_c;
  logic [7:0]  rd_c, index_c;
  logic [31:0] data_c, sum_c;
  logic [31:0] mem_c [NC];

  opto_reader #(.OPTO_NUM(NC), .RD_LAT(1)) dut_c (
    .i_clk_50m(clk), .i_rst_n(rst_n), .i_opto_make(make_c), .o_opto_rden(rden_c),
    .o_opto_rdaddr(addr_c), .i_opto_rddata(rd_c), .o_period_valid(valid_c),
    .o_period_data(data_c), .o_period_index(index_c), .i_period_ready(ready_c),
    .o_frame_done(done_c), .o_busy(busy_c), .o_make_drop(drop_c), .o_period_sum(sum_c)
  );

  always @(posedge clk)
    if (rden_c) rd_c <= mem_c[int'(addr_c[9:2])][8*(3-int'(addr_c[1:0])) +: 8];

  // ---------------- monitors / scoreboards (sample on negedge) ----------------
  logic [39:0] q_a[$], q_b[$];
  logic [39:0] exp_a, exp_b;
  logic [9:0]  addr_log_a[$], addr_log_b[$];
  int rden_cnt_a = 0, xfer_cnt_a = 0, done_cnt_a = 0, drop_cnt_a = 0;
  int xfer_cnt_b = 0, done_cnt_b = 0, xfer_cnt_c = 0, done_cnt_c = 0;
  int unsigned make_cyc_a, first_lat_a, make_cyc_b, first_lat_b, xfer_cyc_b, done_cyc_b;
  bit first_pending_a = 1'b0, first_pending_b = 1'b0;
  logic [31:0] sum_at_done_c = '0;

  initial forever begin
    @(negedge clk);
    if (rden_a) begin rden_cnt_a++; addr_log_a.push_back(addr_a); end
    if (done_a) done_cnt_a++;
    if (drop_a) drop_cnt_a++;
    if (valid_a && first_pending_a) begin
      first_lat_a = cyc - make_cyc_a;
      first_pending_a = 1'b0;
    end
    if (valid_a && ready_a) begin
      xfer_cnt_a++;
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL a_word: got index %0d data %h, no word expected", index_a, data_a);
      end else begin
        exp_a = q_a.pop_front();
        if ({index_a, data_a} !== exp_a) begin
          errors++;
          $display("FAIL a_word: got index %0d data %h, required index %0d data %h",
                   index_a, data_a, exp_a[39:32], exp_a[31:0]);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rden_b) addr_log_b.push_back(addr_b);
    if (done_b) begin done_cnt_b++; done_cyc_b = cyc; end
    if (valid_b && first_pending_b) begin
      first_lat_b = cyc - make_cyc_b;
      first_pending_b = 1'b0;
    end
    if (valid_b && ready_b) begin
      xfer_cnt_b++;
      xfer_cyc_b = cyc;
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL b_word: got index %0d data %h, no word expected", index_b, data_b);
      end else begin
        exp_b = q_b.pop_front();
        if ({index_b, data_b} !== exp_b) begin
          errors++;
          $display("FAIL b_word: got index %0d data %h, required index %0d data %h",
                   index_b, data_b, exp_b[39:32], exp_b[31:0]);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (valid_c && ready_c) xfer_cnt_c++;
    if (done_c) begin done_cnt_c++; sum_at_done_c = sum_c; end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load_a(input logic [31:0] base);
    q_a.delete();
    for (int k = 0; k < NA; k++) begin
      mem_a[k] = base + 32'(k);
      q_a.push_back({8'(k), base + 32'(k)});
    end
  endtask

  task automatic start_a();
    @(posedge clk); #1;
    make_a = 1'b1;
    make_cyc_a = cyc;
    first_pending_a = 1'b1;
    @(posedge clk); #1;
    make_a = 1'b0;
  endtask

  task automatic wait_done(input int which, input int prev, input string name);
    int n = 0;
    int cur;
    cur = (which == 0) ? done_cnt_a : (which == 1) ? done_cnt_b : done_cnt_c;
    while (cur == prev && n < 3000) begin
      @(posedge clk);
      n++;
      cur = (which == 0) ? done_cnt_a : (which == 1) ? done_cnt_b : done_cnt_c;
    end
    #1;
    checks++;
    if (cur == prev) begin
      errors++;
      $display("FAIL %s_done_timeout: frame_done count %0d, required above %0d", name, cur, prev);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rden_a, addr_a, valid_a, data_a, index_a, done_a, busy_a, drop_a, sum_a} !== '0) begin
      errors++;
      $display("FAIL reset_a: outputs %h, required all 0",
               {rden_a, addr_a, valid_a, data_a, index_a, done_a, busy_a, drop_a, sum_a});
    end
    checks++;
    if ({rden_b, addr_b, valid_b, data_b, index_b, done_b, busy_b, drop_b, sum_b} !== '0) begin
      errors++;
      $display("FAIL reset_b: outputs %h, required all 0",
               {rden_b, addr_b, valid_b, data_b, index_b, done_b, busy_b, drop_b, sum_b});
    end
    checks++;
    if ({rden_c, addr_c, valid_c, data_c, index_c, done_c, busy_c, drop_c, sum_c} !== '0) begin
      errors++;
      $display("FAIL reset_c: outputs %h, required all 0",
               {rden_c, addr_c, valid_c, data_c, index_c, done_c, busy_c, drop_c, sum_c});
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy_a, rden_a, valid_a} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: busy/rden/valid %b, required 000", {busy_a, rden_a, valid_a});
    end
  endtask

  task automatic test_basic();
    int pd, px, pr, pdr;
    load_a(32'h0100_0000);
    ready_a = 1'b1;
    pd = done_cnt_a; px = xfer_cnt_a; pr = rden_cnt_a; pdr = drop_cnt_a;
    addr_log_a.delete();
    start_a();
    wait_done(0, pd, "basic");
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (first_lat_a !== 9) begin
      errors++; $display("FAIL basic_latency: first valid %0d cycles after make, required 9", first_lat_a);
    end
    checks++;
    if (xfer_cnt_a - px !== 40) begin
      errors++; $display("FAIL basic_words: %0d transfers, required 40", xfer_cnt_a - px);
    end
    checks++;
    if (q_a.size() !== 0) begin
      errors++; $display("FAIL basic_missing: %0d words not seen, required 0", q_a.size());
    end
    checks++;
    if (done_cnt_a - pd !== 1) begin
      errors++; $display("FAIL basic_done: %0d frame_done pulses, required 1", done_cnt_a - pd);
    end
    checks++;
    if (drop_cnt_a - pdr !== 0 || rden_cnt_a - pr !== 160) begin
      errors++; $display("FAIL basic_rden: drops %0d rden %0d, required 0 and 160",
                         drop_cnt_a - pdr, rden_cnt_a - pr);
    end
    for (int i = 0; i < 160; i++) begin
      checks++;
      if (i >= addr_log_a.size()) begin
        errors++; $display("FAIL basic_addr: read %0d missing, required address %0d", i, i);
      end else if (addr_log_a[i] !== 10'(i)) begin
        errors++; $display("FAIL basic_addr: read %0d address %0d, required %0d", i, addr_log_a[i], i);
      end
    end
    checks++;
    if (busy_a !== 1'b0) begin
      errors++; $display("FAIL basic_busy: busy %b after frame, required 0", busy_a);
    end
  endtask

  task automatic test_stall();
    int pd, px, r0, n;
    load_a(32'h0200_0000);
    ready_a = 1'b1;
    pd = done_cnt_a; px = xfer_cnt_a;
    start_a();
    n = 0;
    while (!(index_a == 8'd4 && !valid_a) && n < 500) begin @(posedge clk); #1; n++; end
    ready_a = 1'b0;
    n = 0;
    while (!(valid_a && index_a == 8'd5) && n < 500) begin @(posedge clk); #1; n++; end
    r0 = rden_cnt_a;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({valid_a, index_a, data_a} !== {1'b1, 8'd5, 32'h0200_0005}) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d valid %b index %0d data %h, required 1 5 02000005",
                 i, valid_a, index_a, data_a);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (rden_cnt_a !== r0) begin
      errors++; $display("FAIL stall_rden: %0d reads during stall, required 0", rden_cnt_a - r0);
    end
    ready_a = 1'b1;
    wait_done(0, pd, "stall");
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (xfer_cnt_a - px !== 40 || q_a.size() !== 0) begin
      errors++; $display("FAIL stall_words: %0d transfers %0d left, required 40 and 0",
                         xfer_cnt_a - px, q_a.size());
    end
  endtask

  task automatic test_drop();
    int pd, px, pdr, n;
    load_a(32'h0300_0000);
    pd = done_cnt_a; px = xfer_cnt_a; pdr = drop_cnt_a;
    start_a();
    n = 0;
    while (!(valid_a && index_a == 8'd10) && n < 500) begin @(posedge clk); #1; n++; end
    make_a = 1'b1;
    @(posedge clk); #1;
    make_a = 1'b0;
    wait_done(0, pd, "drop");
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (drop_cnt_a - pdr !== 1) begin
      errors++; $display("FAIL drop_pulse: %0d make_drop pulses, required 1", drop_cnt_a - pdr);
    end
    checks++;
    if (xfer_cnt_a - px !== 40 || q_a.size() !== 0 || done_cnt_a - pd !== 1) begin
      errors++; $display("FAIL drop_frame: %0d transfers %0d done, required 40 and 1",
                         xfer_cnt_a - px, done_cnt_a - pd);
    end
  endtask

  task automatic test_reset_mid();
    int pd, px, n;
    load_a(32'h0400_0000);
    start_a();
    n = 0;
    while (!(valid_a && index_a == 8'd20) && n < 500) begin @(posedge clk); #1; n++; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rden_a, addr_a, valid_a, data_a, index_a, done_a, busy_a, drop_a, sum_a} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: %h, required all 0",
               {rden_a, addr_a, valid_a, data_a, index_a, done_a, busy_a, drop_a, sum_a});
    end
    pd = done_cnt_a;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    checks++;
    if (done_cnt_a !== pd || busy_a !== 1'b0 || valid_a !== 1'b0) begin
      errors++; $display("FAIL midreset_discard: done %0d busy %b valid %b, required %0d 0 0",
                         done_cnt_a, busy_a, valid_a, pd);
    end
    load_a(32'h0500_0000);
    addr_log_a.delete();
    px = xfer_cnt_a;
    start_a();
    wait_done(0, pd, "restart");
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (addr_log_a.size() == 0) begin
      errors++; $display("FAIL restart_addr: no reads, required first address 0");
    end else if (addr_log_a[0] !== 10'd0) begin
      errors++; $display("FAIL restart_addr: first address %0d, required 0", addr_log_a[0]);
    end
    checks++;
    if (xfer_cnt_a - px !== 40 || q_a.size() !== 0) begin
      errors++; $display("FAIL restart_words: %0d transfers, required 40", xfer_cnt_a - px);
    end
  endtask

  task automatic test_lat3();
    int pd, sz;
    mem_b0 = 32'hA1B2_C3D4;
    q_b.delete();
    q_b.push_back({8'd0, 32'hA1B2_C3D4});
    addr_log_b.delete();
    pd = done_cnt_b;
    @(posedge clk); #1;
    make_b = 1'b1;
    make_cyc_b = cyc;
    first_pending_b = 1'b1;
    @(posedge clk); #1;
    make_b = 1'b0;
    wait_done(1, pd, "lat3");
    repeat (2) @(posedge clk);
    #1;
    sz = addr_log_b.size();
    checks++;
    if (sz !== 4) begin
      errors++; $display("FAIL lat3_reads: %0d reads, required 4", sz);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= sz) begin
        errors++; $display("FAIL lat3_addr: read %0d missing, required address %0d", i, i);
      end else if (addr_log_b[i] !== 10'(i)) begin
        errors++; $display("FAIL lat3_addr: read %0d address %0d, required %0d", i, addr_log_b[i], i);
      end
    end
    checks++;
    if (first_lat_b !== 17) begin
      errors++; $display("FAIL lat3_latency: first valid %0d cycles after make, required 17", first_lat_b);
    end
    checks++;
    if (done_cyc_b !== xfer_cyc_b + 1) begin
      errors++; $display("FAIL lat3_done: done in cycle %0d, required %0d", done_cyc_b, xfer_cyc_b + 1);
    end
    checks++;
    if (q_b.size() !== 0 || done_cnt_b - pd !== 1) begin
      errors++; $display("FAIL lat3_frame: %0d words left %0d done, required 0 and 1",
                         q_b.size(), done_cnt_b - pd);
    end
  endtask

  task automatic test_sum();
    logic [31:0] model;
    logic [31:0] exp_sum;
    int pd, px;
    for (int pass = 0; pass < 2; pass++) begin
      model = '0;
      for (int k = 0; k < NC; k++) begin
        mem_c[k] = (pass == 0) ? 32'(k + 1) : 32'h4000_0000;
        model = model + mem_c[k];
      end
      exp_sum = SUM_EN ? model : 32'h0;
      pd = done_cnt_c; px = xfer_cnt_c;
      @(posedge clk); #1;
      make_c = 1'b1;
      @(posedge clk); #1;
      make_c = 1'b0;
      wait_done(2, pd, "sum");
      checks++;
      if (sum_at_done_c !== exp_sum) begin
        errors++; $display("FAIL sum_done: pass %0d sum %h at done, required %h",
                           pass, sum_at_done_c, exp_sum);
      end
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (sum_c !== exp_sum || xfer_cnt_c - px !== NC) begin
        errors++; $display("FAIL sum_hold: pass %0d sum %h transfers %0d, required %h and %0d",
                           pass, sum_c, xfer_cnt_c - px, exp_sum, NC);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    make_a = 1'b0; make_b = 1'b0; make_c = 1'b0;
    ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_drop();
    test_reset_mid();
    test_lat3();
    test_sum();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
